// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  localparam logic [15:0] NOP_INSTR   = 16'h0000;
  localparam logic [15:0] INSTR_BYTES = 16'd2;

  // 16-bit modulo increment: FFFE wraps to 0000.
  function automatic logic [15:0] pc_incr(input logic [15:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: asynchronous active-low reset to RESET_PC, load on pc_wen.
module fetch_pc_reg #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_wen,
  input  logic [15:0] pc_next,
  output logic [15:0] pc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (pc_wen) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: FETCH/WAIT/HALTED control, branch redirect latch, F/D outputs.
// Optional stall-cycle counter is built when FETCH_STALL_CNT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic        fd_wen,
  output logic [15:0] instruction_out,
  output logic [15:0] oldPC_out,
  output logic [15:0] newPC_out,
  output logic        halt_out,
  output logic        fetch_busy,
  output logic [15:0] stall_count
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic         redirect_pending;
  logic [15:0]  redirect_target;
  logic [15:0]  pc;
  logic [15:0]  pc_next;
  logic         pc_wen;
  logic         pend_set;
  logic         pend_clr;
  logic         deliver;
  logic         is_halt;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .pc_wen  (pc_wen),
    .pc_next (pc_next),
    .pc      (pc)
  );

  assign is_halt = (imem_rdata[15:12] == HALT_OPCODE);

  // Next-state decode: branch beats stall and ready; a pending redirect squashes the returned word.
  always_comb begin
    state_next = state;
    pc_wen     = 1'b0;
    pc_next    = pc;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    deliver    = 1'b0;
    case (state)
      ST_FETCH, ST_WAIT: begin
        if (branch_taken && (state == ST_FETCH || imem_ready)) begin
          pc_wen     = 1'b1;
          pc_next    = branch_target;
          pend_clr   = 1'b1;
          state_next = ST_FETCH;
        end else if (branch_taken) begin
          pend_set = 1'b1;
        end else if (!imem_ready) begin
          state_next = ST_WAIT;
        end else begin
          state_next = ST_FETCH;
          if (redirect_pending) begin
            pc_wen   = 1'b1;
            pc_next  = redirect_target;
            pend_clr = 1'b1;
          end else if (!stall) begin
            deliver = 1'b1;
            if (is_halt) begin
              state_next = ST_HALTED;
            end else begin
              pc_wen  = 1'b1;
              pc_next = pc_incr(pc);
            end
          end
        end
      end
      ST_HALTED: begin
        if (branch_taken) begin
          pc_wen     = 1'b1;
          pc_next    = branch_target;
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_FETCH;
      redirect_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (pend_set) begin
        redirect_pending <= 1'b1;
      end else if (pend_clr) begin
        redirect_pending <= 1'b0;
      end
    end
  end

  // Target latch is pure data; it is only read while redirect_pending is set.
  always_ff @(posedge clk) begin
    if (pend_set) begin
      redirect_target <= branch_target;
    end
  end

  assign imem_req        = rst && (state != ST_HALTED);
  assign imem_addr       = pc;
  assign fd_wen          = rst && deliver;
  assign instruction_out = fd_wen ? imem_rdata : NOP_INSTR;
  assign oldPC_out       = pc;
  assign newPC_out       = pc_incr(pc);
  assign halt_out        = rst && ((state == ST_HALTED) || (deliver && is_halt));
  assign fetch_busy      = rst && (state == ST_WAIT);

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'h0000;
    end else if (stall && (state != ST_HALTED) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_count = stall_cnt;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC loaded on reset.
REQ-002 Parameter HALT_OPCODE, default 4'hF: instr[15:12] value identifying HLT.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  hazard-unit hold; no F/D write, PC holds.
REQ-006 branch_taken  in  1  redirect from decode; pulse, one cycle.
REQ-007 branch_target  in  16  redirect PC.
REQ-008 imem_req  out  1  instruction memory read request.
REQ-009 imem_addr  out  16  fetch address (current PC).
REQ-010 imem_rdata  in  16  instruction word, valid when imem_ready=1.
REQ-011 imem_ready  in  1  memory data valid this cycle; may lag imem_req by any number of cycles.
REQ-012 fd_wen  out  1  write enable to the F/D pipeline register.
REQ-013 instruction_out  out  16  instruction to F/D.
REQ-014 oldPC_out  out  16  PC of delivered instruction.
REQ-015 newPC_out  out  16  oldPC_out + 2.
REQ-016 halt_out  out  1  HLT fetched or fetch halted.
REQ-017 fetch_busy  out  1  waiting on memory (WAIT state).
REQ-018 stall_count  out  16  stall-cycle counter (see REQ-035).

Function
REQ-019 FSM states FETCH, WAIT, HALTED.
REQ-020 FETCH/WAIT: imem_req=1, imem_addr=PC; HALTED: imem_req=0, imem_addr=PC.
REQ-021 FETCH with imem_ready=0 -> WAIT; WAIT holds address until imem_ready=1, then -> FETCH.
REQ-022 Delivery = imem_ready=1 & stall=0 & no pending/current redirect: fd_wen=1, instruction_out=imem_rdata, oldPC_out=PC, newPC_out=PC+2, PC<=PC+2 next edge.
REQ-023 PC arithmetic is 16-bit modulo; PC 16'hFFFE increments to 16'h0000.
REQ-024 imem_ready=1 with stall=1: data discarded, fd_wen=0, PC holds, state FETCH (same address re-fetched).
REQ-025 branch_taken=1 in FETCH: fd_wen=0, PC<=branch_target, state FETCH; priority over stall and imem_ready.
REQ-026 branch_taken=1 in WAIT: redirect_pending<=1, target latched; on later imem_ready returned word discarded, PC<=latched target, pending cleared, -> FETCH.
REQ-027 Second branch_taken while pending overwrites latched target.
REQ-028 Delivered word with instr[15:12]==HALT_OPCODE: halt_out=1 that cycle, PC holds, -> HALTED.
REQ-029 HALTED: fd_wen=0, halt_out=1, PC frozen.
REQ-030 branch_taken in HALTED: PC<=branch_target, halt_out=0 next cycle, -> FETCH (squashes speculative HLT).
REQ-031 When fd_wen=0 instruction_out=NOP_INSTR, oldPC_out/newPC_out=PC/PC+2, halt_out=0 except in HALTED.

Reset
REQ-032 rst low: PC=RESET_PC, state FETCH, redirect_pending=0, stall_count=0, asynchronously.
REQ-033 Outputs during reset: fd_wen=0, halt_out=0, fetch_busy=0, instruction_out=NOP_INSTR, imem_req=0.
REQ-034 Reset asserted mid-WAIT abandons the outstanding request; first request after release uses RESET_PC.

Configuration
REQ-035 Macro FETCH_STALL_CNT_EN defined: stall_count increments each cycle stall=1 and state!=HALTED, saturating at 16'hFFFF; undefined: counter not built, stall_count tied 16'h0000.

Structure
REQ-036 Package fetch_pkg holds fetch_state_t enum, NOP_INSTR=16'h0000, INSTR_BYTES=2.
REQ-037 PC register with async active-low reset and write enable is sub-module fetch_pc_reg; FSM and redirect latch in fetch_stage.

Verification
REQ-038 Reset release, imem_ready=1 always, 3 cycles -> fd_wen=1, oldPC_out 0000,0002,0004, newPC_out 0002,0004,0006.
REQ-039 imem_ready low 3 cycles at PC=0004 -> fetch_busy=1 for 3 cycles, imem_addr=0004 held, fd_wen=0, then delivery of 0004.
REQ-040 stall=1 2 cycles at PC=0008 -> fd_wen=0, PC holds 0008, stall_count +2 with FETCH_STALL_CNT_EN, 0 without.
REQ-041 branch_taken target 0040 during WAIT, ready 2 cycles later -> that word squashed, next imem_addr=0040.
REQ-042 imem_rdata=F000 at PC=0010 -> halt_out=1, HALTED, imem_req=0; branch_taken target 0020 -> FETCH at 0020, halt_out=0.
REQ-043 PC=FFFE delivered -> next imem_addr=0000, newPC_out=0000.
